// File: rtl/sparse_addr_rf_gen.sv
// sparse_addr_rf_gen: maps sparse weight entries to activation RF coordinates.
// Optional macro ADDR_RF_DROP_CNT_EN adds o_drop_cnt (dropped-tap counter).
module sparse_addr_rf_gen #(
  parameter int IA_ROW  = 32,
  parameter int IA_COL  = 32,
  parameter int R_BW    = 2,
  parameter int S_BW    = 2,
  parameter int K_BW    = 3,
  parameter int PTR_BW  = 10,
  parameter int LEN_MAX = 512,
  parameter int STRIDE  = 1,
  parameter int PAD     = 1
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_start,
  input  logic [$clog2(IA_ROW)-1:0]           i_h,
  input  logic [$clog2(IA_COL)-1:0]           i_w,
  input  logic [$clog2(LEN_MAX+1)-1:0]        i_length,
  input  logic                                i_valid,
  output logic                                o_ready,
  input  logic [R_BW-1:0]                     i_r,
  input  logic [S_BW-1:0]                     i_s,
  input  logic [K_BW-1:0]                     i_k,
  input  logic [PTR_BW-1:0]                   i_ptr,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [K_BW-1:0]                     o_k,
  output logic [$clog2(IA_ROW)-1:0]           o_row,
  output logic [$clog2(IA_COL)-1:0]           o_col,
  output logic [$clog2(IA_ROW*IA_COL)-1:0]    o_addr,
  output logic [PTR_BW-1:0]                   o_ptr,
`ifdef ADDR_RF_DROP_CNT_EN
  output logic [$clog2(LEN_MAX+1)-1:0]        o_drop_cnt,
`endif
  output logic                                o_busy,
  output logic                                o_finish
);

  localparam int HW = $clog2(IA_ROW);
  localparam int WW = $clog2(IA_COL);
  localparam int LW = $clog2(LEN_MAX+1);
  localparam int AW = $clog2(IA_ROW*IA_COL);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_q;
  logic [WW-1:0] w_q;
  logic [LW-1:0] len_q, cnt_q;

  logic              vld_q;
  logic [K_BW-1:0]   k_q;
  logic [HW-1:0]     row_q;
  logic [WW-1:0]     col_q;
  logic [AW-1:0]     addr_q;
  logic [PTR_BW-1:0] ptr_q;

  logic          accept;
  logic          inb;
  int            row_c;
  int            col_c;
  logic [AW-1:0] addr_c;

  // Next state and input handshake; RUN exits once all entries
  // are consumed and the output register has drained.
  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) state_d = RUN;
      end
      RUN: begin
        o_ready = (cnt_q < len_q) && (!vld_q || i_ready);
        if ((cnt_q == len_q) && !vld_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign accept = i_valid && o_ready;

  // Signed tap position with stride and padding, plus bounds test
  always_comb begin
    row_c  = int'(h_q) * STRIDE + int'(i_r) - PAD;
    col_c  = int'(w_q) * STRIDE + int'(i_s) - PAD;
    inb    = (row_c >= 0) && (row_c < IA_ROW) &&
             (col_c >= 0) && (col_c < IA_COL);
    addr_c = AW'(row_c[HW-1:0]) * AW'(IA_COL) +
             AW'(col_c[WW-1:0]);
  end

  // State register, job parameter latch and entry counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      h_q     <= '0;
      w_q     <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && i_start) begin
        h_q   <= i_h;
        w_q   <= i_w;
        len_q <= i_length;
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + LW'(1);
      end
    end
  end

  // One-deep output register; a new load overrides the drain
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q  <= 1'b0;
      k_q    <= '0;
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
      ptr_q  <= '0;
    end else if (accept && inb) begin
      vld_q  <= 1'b1;
      k_q    <= i_k;
      row_q  <= row_c[HW-1:0];
      col_q  <= col_c[WW-1:0];
      addr_q <= addr_c;
      ptr_q  <= i_ptr;
    end else if (i_ready) begin
      vld_q  <= 1'b0;
    end
  end

`ifdef ADDR_RF_DROP_CNT_EN
  logic [LW-1:0] drop_q;

  // Count out-of-bounds taps of the current job
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      drop_q <= '0;
    end else if ((state_q == IDLE) && i_start) begin
      drop_q <= '0;
    end else if (accept && !inb) begin
      drop_q <= drop_q + LW'(1);
    end
  end

  assign o_drop_cnt = drop_q;
`endif

  assign o_valid  = vld_q;
  assign o_k      = k_q;
  assign o_row    = row_q;
  assign o_col    = col_q;
  assign o_addr   = addr_q;
  assign o_ptr    = ptr_q;
  assign o_busy   = (state_q != IDLE);
  assign o_finish = (state_q == DONE);

endmodule

// File: tb/tb_sparse_addr_rf_gen.sv
// tb_sparse_addr_rf_gen: table vectors, corner sequences and a random
// stream against an arithmetic reference model.
module tb_sparse_addr_rf_gen;

  localparam int IA_ROW = 32;
  localparam int IA_COL = 32;
  localparam int STRIDE = 1;
  localparam int PAD    = 1;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic [4:0] i_h = '0;
  logic [4:0] i_w = '0;
  logic [9:0] i_length = '0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [1:0] i_r = '0;
  logic [1:0] i_s = '0;
  logic [2:0] i_k = '0;
  logic [9:0] i_ptr = '0;
  logic       o_valid;
  logic       i_ready = 1'b1;
  logic [2:0] o_k;
  logic [4:0] o_row;
  logic [4:0] o_col;
  logic [9:0] o_addr;
  logic [9:0] o_ptr;
`ifdef ADDR_RF_DROP_CNT_EN
  logic [9:0] o_drop_cnt;
`endif
  logic       o_busy;
  logic       o_finish;

  always #5 clk = ~clk;

  sparse_addr_rf_gen dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_h       (i_h),
    .i_w       (i_w),
    .i_length  (i_length),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_r       (i_r),
    .i_s       (i_s),
    .i_k       (i_k),
    .i_ptr     (i_ptr),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_k       (o_k),
    .o_row     (o_row),
    .o_col     (o_col),
    .o_addr    (o_addr),
    .o_ptr     (o_ptr),
`ifdef ADDR_RF_DROP_CNT_EN
    .o_drop_cnt(o_drop_cnt),
`endif
    .o_busy    (o_busy),
    .o_finish  (o_finish)
  );

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] s;
    logic [2:0] k;
    logic [9:0] p;
  } ent_t;

  typedef struct packed {
    logic [2:0] k;
    logic [4:0] row;
    logic [4:0] col;
    logic [9:0] addr;
    logic [9:0] p;
  } out_t;

  typedef struct {
    bit first;
    int h, w, len;
    int r, s, k, p;
    bit emit;
    int er, ec, ea;
  } vec_t;

  localparam int NV = 9;
  vec_t tbl [NV];

  ent_t in_q [$];
  out_t exp_q [$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: tap position straight from the convolution geometry
  function automatic bit model(input int h, input int w,
                               input ent_t e, output out_t o);
    int row, col;
    row = h * STRIDE + int'(e.r) - PAD;
    col = w * STRIDE + int'(e.s) - PAD;
    o.k    = e.k;
    o.p    = e.p;
    o.row  = row[4:0];
    o.col  = col[4:0];
    o.addr = 10'(row * IA_COL + col);
    return (row >= 0) && (row < IA_ROW) && (col >= 0) && (col < IA_COL);
  endfunction

  task automatic wait_finish(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      #1;
      if (o_finish) seen = 1;
      @(negedge clk);
    end
    chk(name, seen, 1);
  endtask

  task automatic run_job(input int h, input int w, input int len,
                         input bit rnd, input bit restart,
                         input int drops);
    int   idx, extra, cyc, fx;
    bit   done;
    out_t e;
    idx = 0; extra = 0; cyc = 0; done = 0;
    @(negedge clk);
    i_start = 1'b1; i_h = 5'(h); i_w = 5'(w); i_length = 10'(len);
    i_valid = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    while (!done && cyc < 4000) begin
      if (restart && cyc == 1) begin
        i_start = 1'b1; i_h = 5'd0; i_w = 5'd0; i_length = 10'd1;
      end else begin
        i_start = 1'b0;
      end
      if (idx < len) begin
        i_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        {i_r, i_s, i_k, i_ptr} = in_q[idx];
      end else begin
        i_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        {i_r, i_s, i_k, i_ptr} = 17'($urandom);
      end
      i_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out actual row=%0d col=%0d required none",
                   o_row, o_col);
        end else begin
          e = exp_q.pop_front();
          chk("out_k", o_k, e.k);
          chk("out_row", o_row, e.row);
          chk("out_col", o_col, e.col);
          chk("out_addr", o_addr, e.addr);
          chk("out_ptr", o_ptr, e.p);
        end
      end
      if (i_valid && o_ready) begin
        if (idx < len) idx++;
        else extra++;
      end
      if (o_finish) done = 1;
      @(negedge clk);
      cyc++;
    end
    i_valid = 1'b0; i_start = 1'b0; i_ready = 1'b1;
    chk("finish_seen", done, 1);
    chk("entries_accepted", idx, len);
    chk("extra_accepts", extra, 0);
    chk("outputs_missing", exp_q.size(), 0);
`ifdef ADDR_RF_DROP_CNT_EN
    chk("drop_cnt", o_drop_cnt, drops);
`else
    if (drops < 0) chk("drops_arg", drops, 0);
`endif
    #1;
    chk("busy_after_finish", o_busy, 0);
    fx = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (o_finish || o_busy || o_valid) fx++;
    end
    chk("idle_after_job", fx, 0);
    in_q.delete();
    exp_q.delete();
  endtask

  task automatic load_job(input int first_idx, output int next_idx,
                          output int drops);
    ent_t e;
    out_t o;
    int   j;
    j = first_idx;
    drops = 0;
    do begin
      e.r = 2'(tbl[j].r); e.s = 2'(tbl[j].s);
      e.k = 3'(tbl[j].k); e.p = 10'(tbl[j].p);
      in_q.push_back(e);
      if (tbl[j].emit) begin
        o.k = e.k; o.p = e.p;
        o.row = 5'(tbl[j].er); o.col = 5'(tbl[j].ec);
        o.addr = 10'(tbl[j].ea);
        exp_q.push_back(o);
      end else begin
        drops++;
      end
      j++;
    end while (j < NV && !tbl[j].first);
    next_idx = j;
  endtask

  initial begin
    int   i, nxt, drops, len, h, w;
    ent_t e;
    out_t o;

    tbl[0] = '{1, 10, 11, 3, 0, 0, 1, 0,   1, 9, 10, 298};
    tbl[1] = '{0, 10, 11, 3, 1, 2, 2, 3,   1, 10, 12, 332};
    tbl[2] = '{0, 10, 11, 3, 2, 1, 3, 6,   1, 11, 11, 363};
    tbl[3] = '{1, 0, 0, 2,   0, 1, 0, 5,   0, 0, 0, 0};
    tbl[4] = '{1, 0, 0, 2,   1, 1, 4, 7,   1, 0, 0, 0};
    tbl[3].first = 1; tbl[4].first = 0;
    tbl[5] = '{1, 31, 31, 3, 1, 1, 5, 100, 1, 31, 31, 1023};
    tbl[6] = '{0, 31, 31, 3, 2, 1, 6, 200, 0, 0, 0, 0};
    tbl[7] = '{0, 31, 31, 3, 1, 2, 7, 300, 0, 0, 0, 0};
    tbl[8] = '{1, 0, 31, 1,  1, 0, 2, 511, 1, 0, 30, 30};

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_finish", o_finish, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_row", o_row, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_ptr", o_ptr, 0);
`ifdef ADDR_RF_DROP_CNT_EN
    chk("rst_drop", o_drop_cnt, 0);
`endif
    @(negedge clk);
    i_rst = 1'b0;

    // table-driven jobs
    i = 0;
    while (i < NV) begin
      load_job(i, nxt, drops);
      run_job(tbl[i].h, tbl[i].w, tbl[i].len, 0, 0, drops);
      i = nxt;
    end

    // zero-length job
    @(negedge clk);
    i_start = 1'b1; i_length = 10'd0; i_h = 5'd3; i_w = 5'd3;
    #1 chk("len0_busy_c0", o_busy, 0);
    @(negedge clk);
    i_start = 1'b0;
    #1;
    chk("len0_busy_c1", o_busy, 1);
    chk("len0_finish_c1", o_finish, 0);
    chk("len0_valid_c1", o_valid, 0);
    @(negedge clk);
    #1;
    chk("len0_busy_c2", o_busy, 1);
    chk("len0_finish_c2", o_finish, 1);
    chk("len0_valid_c2", o_valid, 0);
    @(negedge clk);
    #1;
    chk("len0_busy_c3", o_busy, 0);
    chk("len0_finish_c3", o_finish, 0);

    // backpressure with a full output register
    @(negedge clk);
    i_start = 1'b1; i_h = 5'd10; i_w = 5'd11; i_length = 10'd3;
    i_ready = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    i_start = 1'b0; i_valid = 1'b1;
    {i_r, i_s, i_k, i_ptr} = {2'd0, 2'd0, 3'd1, 10'd0};
    #1 chk("bp_ready_empty", o_ready, 1);
    @(negedge clk);
    {i_r, i_s, i_k, i_ptr} = {2'd1, 2'd2, 3'd2, 10'd3};
    repeat (4) begin
      #1;
      chk("bp_hold_valid", o_valid, 1);
      chk("bp_hold_row", o_row, 9);
      chk("bp_hold_ptr", o_ptr, 0);
      chk("bp_hold_ready", o_ready, 0);
      @(negedge clk);
    end
    i_ready = 1'b1;
    #1;
    chk("bp_rel_row0", o_row, 9);
    chk("bp_rel_ready", o_ready, 1);
    @(negedge clk);
    {i_r, i_s, i_k, i_ptr} = {2'd2, 2'd1, 3'd3, 10'd6};
    #1;
    chk("bp_stream_v1", o_valid, 1);
    chk("bp_stream_row1", o_row, 10);
    chk("bp_stream_ready", o_ready, 1);
    @(negedge clk);
    i_valid = 1'b0;
    #1;
    chk("bp_stream_v2", o_valid, 1);
    chk("bp_stream_row2", o_row, 11);
    chk("bp_stream_addr2", o_addr, 363);
    @(negedge clk);
    #1 chk("bp_drained", o_valid, 0);
    @(negedge clk);
    wait_finish("bp_finish", 10);

    // reset in the middle of a job
    @(negedge clk);
    i_start = 1'b1; i_h = 5'd10; i_w = 5'd11; i_length = 10'd3;
    i_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_valid = 1'b1;
    {i_r, i_s, i_k, i_ptr} = {2'd0, 2'd0, 3'd1, 10'd0};
    @(negedge clk);
    i_valid = 1'b0; i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_finish", o_finish, 0);
    drops = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (o_finish || o_busy) drops++;
    end
    chk("mid_rst_quiet", drops, 0);
    load_job(0, nxt, drops);
    run_job(10, 11, 3, 0, 0, drops);

    // start pulse while running is ignored
    load_job(0, nxt, drops);
    run_job(10, 11, 3, 0, 1, drops);
    load_job(0, nxt, drops);
    run_job(10, 11, 3, 1, 1, drops);

    // randomized jobs with random valid/ready
    for (int n = 0; n < 30; n++) begin
      len = $urandom_range(0, 8);
      h = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 31) :
          (($urandom_range(0, 1) != 0) ? $urandom_range(0, 1) :
                                         $urandom_range(30, 31));
      w = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 31) :
          (($urandom_range(0, 1) != 0) ? $urandom_range(0, 1) :
                                         $urandom_range(30, 31));
      drops = 0;
      for (int m = 0; m < len; m++) begin
        e = ent_t'($urandom);
        in_q.push_back(e);
        if (model(h, w, e, o)) exp_q.push_back(o);
        else drops++;
      end
      run_job(h, w, len, 1, 0, drops);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sparse_addr_rf_gen.md
Name: sparse_addr_rf_gen

Overview:
Parametrised successor to the address-to-RF stage of the sparse conv datapath. Streams compressed weight entries (r, s, k, ptr) over a valid/ready handshake and maps each one to an input-activation RF coordinate and flat address for output position (h, w). Adds stride and padding support, drops out-of-bounds taps, and has a one-deep output register with backpressure. Sits between the sparse weight decoder and the activation RF read port.

Parameters:
IA_ROW, 32, activation rows
IA_COL, 32, activation columns
R_BW, 2, kernel row offset width
S_BW, 2, kernel column offset width
K_BW, 3, output-channel index width
PTR_BW, 10, weight pointer width
LEN_MAX, 512, maximum entries per job
STRIDE, 1, convolution stride (1 to 4)
PAD, 1, zero padding applied on each side

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_start  in  1  job start pulse
i_h  in  $clog2(IA_ROW)  output row position
i_w  in  $clog2(IA_COL)  output column position
i_length  in  $clog2(LEN_MAX+1)  number of entries in the job
i_valid  in  1  weight entry valid
o_ready  out  1  weight entry accepted when i_valid is also high
i_r  in  R_BW  kernel row offset
i_s  in  S_BW  kernel column offset
i_k  in  K_BW  output channel
i_ptr  in  PTR_BW  weight pointer
o_valid  out  1  RF entry valid
i_ready  in  1  downstream ready
o_k  out  K_BW  channel, passed through
o_row  out  $clog2(IA_ROW)  activation row
o_col  out  $clog2(IA_COL)  activation column
o_addr  out  $clog2(IA_ROW*IA_COL)  flat address, o_row*IA_COL+o_col
o_ptr  out  PTR_BW  pointer, passed through
o_busy  out  1  high while a job is active
o_finish  out  1  one-cycle pulse at job end

Behaviour:
- Reset: all outputs 0, FSM returns to IDLE, entry counter 0, output register empty. This applies at any time, including mid-job. No o_finish is generated for an aborted job.
- FSM states: IDLE, RUN, DONE.
  - IDLE to RUN on i_start. In that cycle i_h, i_w and i_length are latched and the counter is cleared.
  - RUN to DONE when counter == length and the output register is empty.
  - DONE to IDLE after one cycle. o_finish = 1 only while in DONE.
- o_busy = (state != IDLE). i_start is ignored while busy.
- o_ready = RUN && (counter < length) && (!o_valid || i_ready).
- Accept = i_valid && o_ready. Each accept increments the counter by 1.
- Address arithmetic, signed, at least 2 bits wider than the widest operand:
  - row = h*STRIDE + r - PAD
  - col = w*STRIDE + s - PAD
- In bounds means 0 <= row < IA_ROW and 0 <= col < IA_COL.
  - In bounds: the output register loads {k, row, col, row*IA_COL+col, ptr} on the next edge and o_valid = 1 (latency 1 cycle).
  - Out of bounds: the entry is consumed and counted, nothing is emitted.
- Output register:
  - Stays stable while o_valid && !i_ready.
  - Clears o_valid on i_ready when no new entry is loaded.
  - Simultaneous i_ready and accept: new data replaces old in the same edge (full throughput, 1 entry/cycle).
- length == 0: RUN immediately satisfies the exit condition. Job runs IDLE, RUN, DONE, and o_finish pulses 2 cycles after i_start with no o_valid.
- Inputs arriving after counter == length are not accepted (o_ready = 0).

Optional Feature:
Macro ADDR_RF_DROP_CNT_EN.
- Defined: adds output port o_drop_cnt, width $clog2(LEN_MAX+1). It counts out-of-bounds entries dropped in the current job, clears on accepted i_start and on i_rst, holds its value after o_finish until the next start.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Defaults, i_ready=1. Start h=10 w=11 len=3, entries (r,s,k,ptr) = (0,0,1,0), (1,2,2,3), (2,1,3,6) -> outputs (row,col,addr) = (9,10,298), (10,12,332), (11,11,363) with k/ptr passed through; o_finish 1 cycle after the last o_valid.
- h=0 w=0 len=2, entries (0,1,0,5), (1,1,4,7) -> first dropped (row=-1); single output row=0 col=0 addr=0 k=4 ptr=7; drop_cnt=1 when the macro is defined.
- len=0 start -> no o_valid; o_busy high 2 cycles; o_finish pulses 2 cycles after i_start.
- Backpressure: i_ready=0 for 4 cycles with the output register full -> o_valid held, o_row/o_ptr stable, o_ready=0; on release, the remaining entries stream at 1 per cycle.
- Reset mid-job after 1 of 3 entries accepted -> next cycle o_valid=0, o_busy=0, no o_finish; a fresh job then completes normally.
- i_start pulsed during RUN with different h/w -> ignored; outputs use the original h/w; exactly one o_finish.
